sha1_arbiter: RTL and testbench



---
 rtl/sha1_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sha1_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_arbiter.sv
// rtl/sha1_arbiter.sv - round-robin sharing of one sha1 engine between requesters
// Grants one job at a time, sequences engine reset/run, guards with a watchdog.
module sha1_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*512-1:0] req_msg,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_id,
  output logic [159:0]           rsp_digest,
  output logic                   rsp_err,
  output logic                   core_reset,
  output logic                   core_on,
  output logic [511:0]           core_message,
  input  logic [159:0]           core_digest,
  input  logic                   core_finish,
  input  logic [5:0]             core_idx,
  output logic                   busy,
  output logic [7:0]             err_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    ABORT = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           cur_id;
  logic [1:0]           last;
  logic [7:0]           cnt;
  logic [NUM_REQ-1:0]   grant;
  logic [1:0]           grant_id;
  logic                 found;
  logic                 unused_idx;

  // Loop index is informational only; it never steers sequencing.
  assign unused_idx = ^core_idx;

  // Round-robin search starting one past the previously granted requester.
  always_comb begin
    int cand;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (i == cand) && req_valid[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          grant_id = 2'(i);
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    core_reset = reset;
    core_on    = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (!reset) begin
          req_ready = grant;
        end
        if (found) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        core_reset = 1'b1;
        state_nxt  = RUN;
      end
      RUN: begin
        core_on = 1'b1;
        // A finish in the final watchdog cycle still delivers the digest.
        if (core_finish) begin
          state_nxt = RESP;
        end else if (cnt == TMO_LAST) begin
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        core_reset = 1'b1;
        state_nxt  = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      core_message <= '0;
      cur_id       <= '0;
      last         <= 2'(NUM_REQ - 1);
      cnt          <= '0;
      rsp_digest   <= '0;
      rsp_err      <= 1'b0;
      err_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            for (int i = 0; i < NUM_REQ; i++) begin
              if (grant[i]) begin
                core_message <= req_msg[i*512 +: 512];
              end
            end
            cur_id <= grant_id;
            last   <= grant_id;
          end
        end
        LOAD: begin
          cnt <= '0;
        end
        RUN: begin
          cnt <= cnt + 8'd1;
          if (core_finish) begin
            rsp_digest <= core_digest;
            rsp_err    <= 1'b0;
          end
        end
        ABORT: begin
          rsp_digest <= '0;
          rsp_err    <= 1'b1;
          if (err_count != 8'hff) begin
            err_count <= err_count + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_id = cur_id;

endmodule

// File: tb/tb_sha1_arbiter.sv
// tb/tb_sha1_arbiter.sv - directed bench for sha1_arbiter with a behavioural engine
module tb_sha1_arbiter;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [159:0] ABC_DIG = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] KEY     = 160'h5a5a5a5a_c3c3c3c3_0f0f0f0f_12345678_9abcdef0;
  localparam logic [511:0] MSG0    = {16{32'ha0a0_0001}};
  localparam logic [511:0] MSG1    = {16{32'hb1b1_0002}};

  logic          clk;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1023:0] req_msg;
  logic [1:0]    req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [159:0]  rsp_digest;
  logic          rsp_err;
  logic          core_reset;
  logic          core_on;
  logic [511:0]  core_message;
  logic [159:0]  core_digest;
  logic          core_finish;
  logic [5:0]    core_idx;
  logic          busy;
  logic [7:0]    err_count;

  logic [7:0]    eng_cnt;
  int            fin_at;
  bit            fin_en;
  int            viol;
  int            n_checks;
  int            n_fail;

  sha1_arbiter #(.NUM_REQ(2), .TIMEOUT(100)) dut (
    .wb_clk_i     (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_msg      (req_msg),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_digest   (rsp_digest),
    .rsp_err      (rsp_err),
    .core_reset   (core_reset),
    .core_on      (core_on),
    .core_message (core_message),
    .core_digest  (core_digest),
    .core_finish  (core_finish),
    .core_idx     (core_idx),
    .busy         (busy),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine stand-in: finishes fin_at cycles into RUN, digest derived from the message.
  always @(posedge clk) begin
    if (core_reset) eng_cnt <= 8'd0;
    else if (core_on) eng_cnt <= eng_cnt + 8'd1;
  end
  assign core_finish = core_on && fin_en && (eng_cnt == 8'(fin_at));
  assign core_idx    = eng_cnt[5:0];
  assign core_digest = (core_message == ABC_BLK) ? ABC_DIG : (core_message[159:0] ^ KEY);

  initial viol = 0;
  always @(negedge clk) begin
    if (busy && (req_ready != 2'b00)) viol = viol + 1;
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_job(input int id, input logic [511:0] msg);
    req_msg[id*512 +: 512] = msg;
    req_valid[id] = 1'b1;
    #1;
    check("grant", 160'(req_ready), 160'(1) << id);
    @(negedge clk);
    req_valid[id] = 1'b0;
    check("load_core_reset", 160'(core_reset), 160'(1));
    check("load_core_on", 160'(core_on), 160'(0));
  endtask

  task automatic wait_rsp(input int n0, output int n, output int rh);
    n  = n0;
    rh = 0;
    do begin
      @(negedge clk);
      n++;
      if (core_reset) rh++;
    end while (!rsp_valid && n < 400);
    check("rsp_seen", 160'(rsp_valid), 160'(1));
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_after_rsp", 160'(busy), 160'(0));
  endtask

  initial begin
    int n;
    int rh;
    int w;
    int dev;
    logic [159:0] snap_d;
    logic [1:0]   snap_id;
    logic         snap_e;

    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    req_valid = 2'b00;
    req_msg   = '0;
    rsp_ready = 1'b0;
    fin_en    = 1'b1;
    fin_at    = 80;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 160'(req_ready), 160'(0));
    check("rst_rsp_valid", 160'(rsp_valid), 160'(0));
    check("rst_digest", rsp_digest, 160'(0));
    check("rst_core_reset", 160'(core_reset), 160'(1));
    check("rst_core_on", 160'(core_on), 160'(0));
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_err_count", 160'(err_count), 160'(0));
    check("rst_message", 160'(core_message[159:0]), 160'(0));
    reset = 1'b0;

    // Single "abc" job from requester 0
    start_job(0, ABC_BLK);
    check("load_message", 160'(core_message[511:480]), 160'(32'h61626380));
    @(negedge clk);
    check("run_core_reset", 160'(core_reset), 160'(0));
    check("run_core_on", 160'(core_on), 160'(1));
    wait_rsp(2, n, rh);
    check("abc_latency", 160'(n), 160'(83));
    check("abc_reset_pulses", 160'(rh), 160'(0));
    check("abc_id", 160'(rsp_id), 160'(0));
    check("abc_digest", rsp_digest, ABC_DIG);
    check("abc_err", 160'(rsp_err), 160'(0));
    release_rsp();

    // Contention: both requesters held valid, grants must alternate
    do_reset();
    req_msg[0 +: 512]   = MSG0;
    req_msg[512 +: 512] = MSG1;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    for (int j = 0; j < 4; j++) begin
      w = 0;
      while (req_ready == 2'b00 && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("rr_grant", 160'(req_ready), (j % 2 == 0) ? 160'(1) : 160'(2));
      wait_rsp(0, n, rh);
      check("rr_latency", 160'(n), 160'(83));
      check("rr_id", 160'(rsp_id), 160'(j % 2));
      check("rr_digest", rsp_digest, ((j % 2 == 0) ? MSG0[159:0] : MSG1[159:0]) ^ KEY);
      if (j == 3) req_valid = 2'b00;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rr_idle", 160'(busy), 160'(0));

    // Watchdog: engine never finishes
    do_reset();
    fin_en = 1'b0;
    start_job(0, MSG0);
    wait_rsp(1, n, rh);
    check("wd_latency", 160'(n), 160'(103));
    check("wd_reset_pulses", 160'(rh), 160'(1));
    check("wd_err", 160'(rsp_err), 160'(1));
    check("wd_digest", rsp_digest, 160'(0));
    check("wd_err_count", 160'(err_count), 160'(1));

    // Backpressure: hold the response for 50 cycles with another request pending
    snap_d  = rsp_digest;
    snap_id = rsp_id;
    snap_e  = rsp_err;
    req_msg[512 +: 512] = MSG1;
    req_valid = 2'b10;
    dev = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_digest !== snap_d || rsp_id !== snap_id ||
          rsp_err !== snap_e || core_on !== 1'b0 || req_ready !== 2'b00) dev++;
    end
    check("bp_stable", 160'(dev), 160'(0));
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle", 160'(busy), 160'(0));
    check("bp_rsp_valid", 160'(rsp_valid), 160'(0));
    check("bp_grant_ready", 160'(req_ready), 160'(2));
    req_valid = 2'b00;
    rsp_ready = 1'b0;

    // Finish in the same cycle as the timeout: digest wins, no error counted
    fin_en = 1'b1;
    fin_at = 99;
    @(negedge clk);
    start_job(0, ABC_BLK);
    wait_rsp(1, n, rh);
    check("tie_latency", 160'(n), 160'(102));
    check("tie_err", 160'(rsp_err), 160'(0));
    check("tie_digest", rsp_digest, ABC_DIG);
    check("tie_err_count", 160'(err_count), 160'(1));
    release_rsp();

    // Reset while running at loop index 40
    fin_at = 80;
    start_job(1, MSG1);
    w = 0;
    while (!(core_on && core_idx == 6'd40) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("mid_idx_reached", 160'(core_idx), 160'(40));
    reset = 1'b1;
    @(negedge clk);
    check("mid_busy", 160'(busy), 160'(0));
    check("mid_rsp_valid", 160'(rsp_valid), 160'(0));
    check("mid_core_on", 160'(core_on), 160'(0));
    check("mid_core_reset", 160'(core_reset), 160'(1));
    check("mid_message", 160'(core_message[159:0]), 160'(0));
    check("mid_rsp_id", 160'(rsp_id), 160'(0));
    check("mid_err_count", 160'(err_count), 160'(0));
    reset = 1'b0;
    @(negedge clk);
    start_job(0, ABC_BLK);
    wait_rsp(1, n, rh);
    check("post_latency", 160'(n), 160'(83));
    check("post_digest", rsp_digest, ABC_DIG);
    check("post_id", 160'(rsp_id), 160'(0));
    release_rsp();

    check("no_grant_while_busy", 160'(viol), 160'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
